svm_vote_decider: RTL and testbench

Sits directly downstream of the RBF kernel accumulator in the SVM classifier. After the last support vector of a flow enters the kernel, it waits for the kernel pipeline to drain and captures the packed per-decision distances. It then applies the per-decision bias (rho) and runs one-vs-one voting. It outputs the winning class with a valid/ready handshake.

---
 rtl/svm_vote_decider.sv | 164 ++++++++++++++++
 tb/tb_svm_vote_decider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_vote_decider.sv
// One-vs-one vote decider for the SVM classifier: waits out the kernel latency,
// captures the per-decision distances, biases them by rho, votes, then picks the argmax class.
module svm_vote_decider #(
  parameter int CLASS_COUNT    = 4,
  parameter int CLASS_WIDTH    = 2,
  parameter int DECISION_COUNT = 6,
  parameter int DIST_WIDTH     = 32,
  parameter int KERNEL_LATENCY = 15,
  parameter int VOTE_WIDTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  start_ready,
  input  logic [DIST_WIDTH*DECISION_COUNT-1:0]  distance,
  input  logic [DIST_WIDTH*DECISION_COUNT-1:0]  rho,
  input  logic [CLASS_WIDTH*DECISION_COUNT-1:0] dec_class1,
  input  logic [CLASS_WIDTH*DECISION_COUNT-1:0] dec_class2,
  output logic [CLASS_WIDTH-1:0]                class_out,
  output logic [VOTE_WIDTH-1:0]                 max_votes,
  output logic                                  class_valid,
  input  logic                                  out_ready,
  output logic                                  busy
);

  localparam int WAIT_W = (KERNEL_LATENCY > 1) ? $clog2(KERNEL_LATENCY) : 1;
  localparam int DEC_W  = (DECISION_COUNT > 1) ? $clog2(DECISION_COUNT) : 1;
  localparam int CIDX_W = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
  localparam logic [VOTE_WIDTH-1:0] VOTE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_VOTE,
    S_SELECT,
    S_OUTPUT
  } state_t;

  state_t                        state;
  logic [WAIT_W-1:0]             wait_cnt;
  logic [DEC_W-1:0]              dec_idx;
  logic [CIDX_W-1:0]             sel_idx;
  logic                          sel_done;
  logic signed [DIST_WIDTH-1:0]  dist_q [DECISION_COUNT];
  logic [VOTE_WIDTH-1:0]         votes [CLASS_COUNT];
  logic [CIDX_W-1:0]             best_class;
  logic [VOTE_WIDTH-1:0]         best_votes;

  logic signed [DIST_WIDTH-1:0]  rho_sel;
  logic signed [DIST_WIDTH:0]    diff;
  logic [CLASS_WIDTH-1:0]        vote_cls;
  logic [CIDX_W-1:0]             vote_idx;
  logic                          vote_ok;
  int                            dsel;

  function automatic logic [VOTE_WIDTH-1:0] sat_inc(input logic [VOTE_WIDTH-1:0] v);
    return (v == VOTE_MAX) ? v : v + VOTE_WIDTH'(1);
  endfunction

  // One extra bit of headroom so distance - rho can never wrap.
  function automatic logic signed [DIST_WIDTH:0] signed_diff(
    input logic signed [DIST_WIDTH-1:0] a,
    input logic signed [DIST_WIDTH-1:0] b
  );
    logic signed [DIST_WIDTH:0] ax;
    logic signed [DIST_WIDTH:0] bx;
    ax = {a[DIST_WIDTH-1], a};
    bx = {b[DIST_WIDTH-1], b};
    return ax - bx;
  endfunction

  function automatic logic is_positive(input logic signed [DIST_WIDTH:0] v);
    return !v[DIST_WIDTH] && (v != '0);
  endfunction

  assign start_ready = (state == S_IDLE);

  always_comb begin
    dsel     = int'(dec_idx);
    rho_sel  = $signed(rho[DIST_WIDTH*dsel +: DIST_WIDTH]);
    diff     = signed_diff(dist_q[dec_idx], rho_sel);
    vote_cls = is_positive(diff) ? dec_class1[CLASS_WIDTH*dsel +: CLASS_WIDTH]
                                 : dec_class2[CLASS_WIDTH*dsel +: CLASS_WIDTH];
    vote_idx = CIDX_W'(vote_cls);
    vote_ok  = int'(vote_cls) < CLASS_COUNT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      dec_idx     <= '0;
      sel_idx     <= '0;
      sel_done    <= 1'b0;
      best_class  <= '0;
      best_votes  <= '0;
      class_out   <= '0;
      max_votes   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
      for (int d = 0; d < DECISION_COUNT; d++) dist_q[d] <= '0;
      for (int c = 0; c < CLASS_COUNT; c++) votes[c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int c = 0; c < CLASS_COUNT; c++) votes[c] <= '0;
            wait_cnt <= WAIT_W'(KERNEL_LATENCY - 1);
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        // Kernel drain: the last support vector's distances land KERNEL_LATENCY edges after start.
        S_WAIT: begin
          if (wait_cnt == '0) begin
            for (int d = 0; d < DECISION_COUNT; d++)
              dist_q[d] <= $signed(distance[DIST_WIDTH*d +: DIST_WIDTH]);
            dec_idx <= '0;
            state   <= S_VOTE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        S_VOTE: begin
          if (vote_ok) votes[vote_idx] <= sat_inc(votes[vote_idx]);
          if (dec_idx == DEC_W'(DECISION_COUNT - 1)) begin
            sel_idx    <= '0;
            sel_done   <= 1'b0;
            best_class <= '0;
            best_votes <= '0;
            state      <= S_SELECT;
          end else begin
            dec_idx <= dec_idx + DEC_W'(1);
          end
        end
        // Strictly-greater replacement keeps the lowest index on ties.
        S_SELECT: begin
          if (sel_done) begin
            class_out   <= CLASS_WIDTH'(best_class);
            max_votes   <= best_votes;
            class_valid <= 1'b1;
            state       <= S_OUTPUT;
          end else begin
            if (votes[sel_idx] > best_votes) begin
              best_votes <= votes[sel_idx];
              best_class <= sel_idx;
            end
            if (sel_idx == CIDX_W'(CLASS_COUNT - 1)) sel_done <= 1'b1;
            else sel_idx <= sel_idx + CIDX_W'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            class_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_vote_decider.sv
// Scoreboard bench for svm_vote_decider: expected winners queued at launch, checked at class_valid.
module tb_svm_vote_decider;
  localparam int CC  = 4;
  localparam int CW  = 2;
  localparam int DC  = 6;
  localparam int DW  = 32;
  localparam int KL  = 15;
  localparam int VW  = 4;
  localparam int LAT = KL + DC + CC + 1;
  localparam logic signed [DW-1:0] ONE = 32'sh0001_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              start_ready;
  logic [DW*DC-1:0]  distance;
  logic [DW*DC-1:0]  rho;
  logic [CW*DC-1:0]  dec_class1;
  logic [CW*DC-1:0]  dec_class2;
  logic [CW-1:0]     class_out;
  logic [VW-1:0]     max_votes;
  logic              class_valid;
  logic              out_ready;
  logic              busy;

  typedef struct packed {
    logic [CW-1:0] cls;
    logic [VW-1:0] votes;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  svm_vote_decider #(
    .CLASS_COUNT(CC), .CLASS_WIDTH(CW), .DECISION_COUNT(DC),
    .DIST_WIDTH(DW), .KERNEL_LATENCY(KL), .VOTE_WIDTH(VW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
    .distance(distance), .rho(rho), .dec_class1(dec_class1), .dec_class2(dec_class2),
    .class_out(class_out), .max_votes(max_votes), .class_valid(class_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_pairs_default();
    int a[DC];
    int b[DC];
    a = '{0, 0, 0, 1, 1, 2};
    b = '{1, 2, 3, 2, 3, 3};
    for (int d = 0; d < DC; d++) begin
      dec_class1[CW*d +: CW] = CW'(a[d]);
      dec_class2[CW*d +: CW] = CW'(b[d]);
    end
  endtask

  task automatic set_all(input logic signed [DW-1:0] dv, input logic signed [DW-1:0] rv);
    for (int d = 0; d < DC; d++) begin
      distance[DW*d +: DW] = dv;
      rho[DW*d +: DW] = rv;
    end
  endtask

  function automatic exp_t model();
    int   v[CC];
    int   best;
    exp_t e;
    for (int c = 0; c < CC; c++) v[c] = 0;
    for (int d = 0; d < DC; d++) begin
      longint df;
      int     c;
      df = longint'($signed(distance[DW*d +: DW])) - longint'($signed(rho[DW*d +: DW]));
      c  = (df > 0) ? int'(dec_class1[CW*d +: CW]) : int'(dec_class2[CW*d +: CW]);
      if (c < CC && v[c] < (1 << VW) - 1) v[c]++;
    end
    best = 0;
    for (int c = 1; c < CC; c++) if (v[c] > v[best]) best = c;
    e.cls   = CW'(best);
    e.votes = VW'(v[best]);
    return e;
  endfunction

  // Called just after an edge; start is sampled on the next edge.
  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (class_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++; if (class_out !== '0) begin miscompares++; $display("FAIL reset_class_out: got %0d expected 0", class_out); end
    vectors++; if (max_votes !== '0) begin miscompares++; $display("FAIL reset_max_votes: got %0d expected 0", max_votes); end
    vectors++; if (class_valid !== 1'b0) begin miscompares++; $display("FAIL reset_class_valid: got %b expected 0", class_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
  endtask

  task automatic test_patterns();
    int   lat;
    exp_t e;
    exp_t want;
    for (int p = 0; p < 6; p++) begin
      case (p)
        0: begin set_all(ONE, '0);  want = '{cls: 2'd0, votes: 4'd3}; end
        1: begin set_all(-ONE, '0); want = '{cls: 2'd3, votes: 4'd3}; end
        2: begin
          set_all(ONE, '0);
          distance[DW*1 +: DW] = -ONE;
          distance[DW*4 +: DW] = -ONE;
          distance[DW*5 +: DW] = -ONE;
          want = '{cls: 2'd0, votes: 4'd2};
        end
        3: begin
          for (int d = 0; d < DC; d++) begin
            rho[DW*d +: DW]      = DW'((d - 3) * 32'sh0001_2345);
            distance[DW*d +: DW] = rho[DW*d +: DW];
          end
          want = '{cls: 2'd3, votes: 4'd3};
        end
        4: begin set_all(32'sh0000_4000, 32'sh0000_8000); want = '{cls: 2'd3, votes: 4'd3}; end
        default: begin set_all(32'sh7FFF_FFFF, 32'sh8000_0000); want = '{cls: 2'd0, votes: 4'd3}; end
      endcase
      sb.push_back(want);
      launch();
      wait_valid(lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++; if (lat != LAT) begin miscompares++; $display("FAIL pattern%0d_latency: got %0d expected %0d", p, lat, LAT); end
      vectors++; if (class_out !== e.cls) begin miscompares++; $display("FAIL pattern%0d_class: got %0d expected %0d", p, class_out, e.cls); end
      vectors++; if (max_votes !== e.votes) begin miscompares++; $display("FAIL pattern%0d_votes: got %0d expected %0d", p, max_votes, e.votes); end
      @(posedge clk); #1;
      vectors++; if (class_valid !== 1'b0) begin miscompares++; $display("FAIL pattern%0d_valid_drop: got %b expected 0", p, class_valid); end
      vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL pattern%0d_idle: got %b expected 1", p, start_ready); end
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    set_all(-ONE, '0);
    sb.push_back('{cls: 2'd3, votes: 4'd3});
    out_ready = 1'b0;
    launch();
    wait_valid(lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      @(posedge clk); #1;
      vectors++; if (class_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", i, class_valid); end
      vectors++; if (class_out !== e.cls) begin miscompares++; $display("FAIL bp_class[%0d]: got %0d expected %0d", i, class_out, e.cls); end
      vectors++; if (max_votes !== e.votes) begin miscompares++; $display("FAIL bp_votes[%0d]: got %0d expected %0d", i, max_votes, e.votes); end
      vectors++; if (start_ready !== 1'b0) begin miscompares++; $display("FAIL bp_start_ready[%0d]: got %b expected 0", i, start_ready); end
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (class_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b expected 0", class_valid); end
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_idle: got %b expected 1", start_ready); end
    set_all(ONE, '0);
    sb.push_back('{cls: 2'd0, votes: 4'd3});
    launch();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_next_accept: got busy %b expected 1", busy); end
    wait_valid(lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL bp_next_latency: got %0d expected %0d", lat, LAT); end
    vectors++; if (class_out !== e.cls) begin miscompares++; $display("FAIL bp_next_class: got %0d expected %0d", class_out, e.cls); end
    vectors++; if (max_votes !== e.votes) begin miscompares++; $display("FAIL bp_next_votes: got %0d expected %0d", max_votes, e.votes); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_flow();
    int   lat;
    exp_t e;
    set_all(-ONE, '0);
    launch();
    repeat (KL + 3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_start_ready: got %b expected 1", start_ready); end
    vectors++; if (class_out !== '0) begin miscompares++; $display("FAIL midreset_class_out: got %0d expected 0", class_out); end
    vectors++; if (max_votes !== '0) begin miscompares++; $display("FAIL midreset_max_votes: got %0d expected 0", max_votes); end
    sb.push_back('{cls: 2'd3, votes: 4'd3});
    launch();
    lat = 0;
    while (class_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == KL) set_all(ONE, '0);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL midreset_latency: got %0d expected %0d", lat, LAT); end
    vectors++; if (class_out !== e.cls) begin miscompares++; $display("FAIL midreset_class: got %0d expected %0d", class_out, e.cls); end
    vectors++; if (max_votes !== e.votes) begin miscompares++; $display("FAIL midreset_votes: got %0d expected %0d", max_votes, e.votes); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < DC; d++) begin
        distance[DW*d +: DW]   = DW'($urandom);
        rho[DW*d +: DW]        = (f < 4) ? DW'($urandom) : DW'($urandom_range(0, 3) - 1);
        dec_class1[CW*d +: CW] = CW'($urandom_range(0, CC - 1));
        dec_class2[CW*d +: CW] = CW'($urandom_range(0, CC - 1));
      end
      sb.push_back(model());
      launch();
      wait_valid(lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++; if (lat != LAT) begin miscompares++; $display("FAIL b2b%0d_latency: got %0d expected %0d", f, lat, LAT); end
      vectors++; if (class_out !== e.cls) begin miscompares++; $display("FAIL b2b%0d_class: got %0d expected %0d", f, class_out, e.cls); end
      vectors++; if (max_votes !== e.votes) begin miscompares++; $display("FAIL b2b%0d_votes: got %0d expected %0d", f, max_votes, e.votes); end
      @(posedge clk); #1;
    end
    set_pairs_default();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    distance = '0;
    rho = '0;
    set_pairs_default();
    test_reset();
    test_patterns();
    test_backpressure();
    test_reset_mid_flow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
